// File: rtl/freq_sweep_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : freq_sweep_ctrl
// Purpose  : Steps freq_gen's freq_sel linearly from start to stop, holding
//            each value for a programmed number of generated-clock edges.
// Revision : 1.0 - initial release
// ============================================================================
module freq_sweep_ctrl #(
  parameter int DATA_WIDTH  = 8,
  parameter int DWELL_WIDTH = 16
) (
  input  logic                   clk_in,
  input  logic                   rst,
  input  logic                   i_start,
  input  logic                   i_abort,
  input  logic [DATA_WIDTH-1:0]  i_freq_start,
  input  logic [DATA_WIDTH-1:0]  i_freq_stop,
  input  logic [DATA_WIDTH-1:0]  i_freq_step,
  input  logic [DWELL_WIDTH-1:0] i_dwell_cycles,
  input  logic                   i_gen_clk,
  output logic [DATA_WIDTH-1:0]  o_freq_sel,
  output logic                   o_busy,
  output logic                   o_step_strobe,
  output logic                   o_done
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_LOAD  = 2'd1,
    S_DWELL = 2'd2,
    S_DONE  = 2'd3
  } state_t;

  state_t                 r_state;
  logic                   r_gen_q;
  logic [DWELL_WIDTH-1:0] r_cnt;
  logic [DATA_WIDTH-1:0]  r_start_l;
  logic [DATA_WIDTH-1:0]  r_stop_l;
  logic [DATA_WIDTH-1:0]  r_step_l;
  logic [DWELL_WIDTH-1:0] r_dwell_l;
  logic                   r_dir_up;
  logic [DATA_WIDTH-1:0]  r_freq_sel;
  logic                   r_busy;
  logic                   r_strobe;
  logic                   r_done;

  logic                   w_gen_rise;
  logic                   w_dwell_end;
  logic                   w_last_step;
  logic [DATA_WIDTH:0]    w_sum;
  logic [DATA_WIDTH:0]    w_diff;
  logic [DATA_WIDTH-1:0]  w_next;

  assign w_gen_rise  = i_gen_clk & ~r_gen_q;
  assign w_dwell_end = (r_cnt == (r_dwell_l - DWELL_WIDTH'(1)));
  assign w_last_step = (r_freq_sel == r_stop_l) || (r_step_l == '0);

  // The extra top bit exposes carry/borrow so wrap-around clamps to stop.
  assign w_sum  = {1'b0, r_freq_sel} + {1'b0, r_step_l};
  assign w_diff = {1'b0, r_freq_sel} - {1'b0, r_step_l};

  always_comb begin
    w_next = r_stop_l;
    if (r_dir_up) begin
      if (!w_sum[DATA_WIDTH] && (w_sum[DATA_WIDTH-1:0] < r_stop_l))
        w_next = w_sum[DATA_WIDTH-1:0];
    end else begin
      if (!w_diff[DATA_WIDTH] && (w_diff[DATA_WIDTH-1:0] > r_stop_l))
        w_next = w_diff[DATA_WIDTH-1:0];
    end
  end

  always_ff @(posedge clk_in) begin
    if (rst) begin
      r_state    <= S_IDLE;
      r_gen_q    <= 1'b0;
      r_cnt      <= '0;
      r_start_l  <= '0;
      r_stop_l   <= '0;
      r_step_l   <= '0;
      r_dwell_l  <= DWELL_WIDTH'(1);
      r_dir_up   <= 1'b1;
      r_freq_sel <= '0;
      r_busy     <= 1'b0;
      r_strobe   <= 1'b0;
      r_done     <= 1'b0;
    end else begin
      r_gen_q  <= i_gen_clk;
      r_strobe <= 1'b0;
      r_done   <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (i_start && !i_abort) begin
            r_start_l <= i_freq_start;
            r_stop_l  <= i_freq_stop;
            r_step_l  <= i_freq_step;
            r_dwell_l <= (i_dwell_cycles == '0) ? DWELL_WIDTH'(1) : i_dwell_cycles;
            r_dir_up  <= (i_freq_start <= i_freq_stop);
            r_busy    <= 1'b1;
            r_state   <= S_LOAD;
          end
        end
        S_LOAD: begin
          if (i_abort) begin
            r_busy  <= 1'b0;
            r_state <= S_IDLE;
          end else begin
            r_freq_sel <= r_start_l;
            r_strobe   <= 1'b1;
            r_cnt      <= '0;
            r_state    <= S_DWELL;
          end
        end
        S_DWELL: begin
          if (i_abort) begin
            r_busy  <= 1'b0;
            r_state <= S_IDLE;
          end else if (w_gen_rise) begin
            if (w_dwell_end) begin
              if (w_last_step) begin
                r_busy  <= 1'b0;
                r_done  <= 1'b1;
                r_state <= S_DONE;
              end else begin
                r_freq_sel <= w_next;
                r_strobe   <= 1'b1;
                r_cnt      <= '0;
              end
            end else begin
              r_cnt <= r_cnt + DWELL_WIDTH'(1);
            end
          end
        end
        S_DONE: begin
          r_state <= S_IDLE;
        end
        default: begin
          r_state <= S_IDLE;
        end
      endcase
    end
  end

  assign o_freq_sel    = r_freq_sel;
  assign o_busy        = r_busy;
  assign o_step_strobe = r_strobe;
  assign o_done        = r_done;

endmodule
`default_nettype wire
